dino_jump_engine: RTL

//  Parametrised dinosaur motion + sprite renderer. Replaces the fixed-parabola jumper.

---
 rtl/dino_pkg.sv | 19 +
 rtl/dino_jump_engine_if.sv | 38 +++
 rtl/dino_sprite_rom.sv | 62 ++++++
 rtl/dino_jump_engine.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared definitions for the dino motion/sprite block and its neighbours.
// The obstacle and collision blocks reuse these geometry constants.
// FSM encodings are kept as plain localparams so older code that stores
// the state in a 1-bit vector still works with them.
package dino_pkg;

  // Motion FSM encodings
  localparam logic [0:0] StGround = 1'b0;
  localparam logic [0:0] StAir    = 1'b1;

  // Default screen geometry (pixels)
  localparam int unsigned DefGroundY = 402;  // row just below the feet
  localparam int unsigned DefX0      = 80;   // left column of the sprite
  localparam int unsigned DefSprW    = 82;
  localparam int unsigned DefSprH    = 88;
  localparam int unsigned DefDuckW   = 110;
  localparam int unsigned DefDuckH   = 52;

endpackage

// File: rtl/dino_jump_engine_if.sv
// Control and video bus between the game/VGA logic and the dino engine.
//   fresh        frame strobe level (falling edge = frame tick)
//   game_status  1 = running, 0 = paused
//   START        clears motion state while paused
//   button_jump  jump request level
//   button_duck  duck request level
//   row_addr     current VGA row
//   col_addr     current VGA column
//   px           registered sprite pixel
//   height       height above ground
//   airborne     1 while the dino is in the air
// master: game/VGA side; slave: the engine.
interface dino_jump_engine_if #(
  parameter int unsigned HW = 10
) ();

  logic          fresh;
  logic          game_status;
  logic          START;
  logic          button_jump;
  logic          button_duck;
  logic [8:0]    row_addr;
  logic [9:0]    col_addr;
  logic          px;
  logic [HW-1:0] height;
  logic          airborne;

  modport master (
    output fresh, game_status, START, button_jump, button_duck, row_addr, col_addr,
    input  px, height, airborne
  );

  modport slave (
    input  fresh, game_status, START, button_jump, button_duck, row_addr, col_addr,
    output px, height, airborne
  );

endinterface

// File: rtl/dino_sprite_rom.sv
// Combinational sprite bitmap lookup: (duck, anim, dy, dx) -> pixel bit.
// Each frame is stored row-major as a set of filled spans; bit dx of row dy
// is set when (dy, dx) falls inside one of the frame's spans.
//   Run frames (82 x 88):
//     head  rows  0..23, cols 42..81, eye hole rows 6..9 cols 66..69
//     body  rows 24..63, cols 10..61
//     tail  rows 30..45, cols  0..9
//     back leg  cols 34..45: rows 64..87 (frame A) / 64..75 (frame B)
//     front leg cols 56..65: rows 64..75 (frame A) / 64..87 (frame B)
//   Duck frame (110 x 52):
//     head  rows  0..19, cols 70..109, eye hole rows 4..7 cols 96..99
//     body  rows 10..39, cols  0..79
//     legs  rows 40..51, cols 20..29 and 50..59
// Ports:
//   duck_i  select duck frame
//   anim_i  run leg phase (0 = frame A, 1 = frame B)
//   dy_i    row offset inside the sprite
//   dx_i    column offset inside the sprite
//   bit_o   pixel bit
module dino_sprite_rom #(
  parameter int unsigned CW = 12
) (
  input  logic          duck_i,
  input  logic          anim_i,
  input  logic [CW-1:0] dy_i,
  input  logic [CW-1:0] dx_i,
  output logic          bit_o
);

  function automatic logic in_span(input int unsigned y, input int unsigned x,
                                   input int unsigned y0, input int unsigned y1,
                                   input int unsigned x0, input int unsigned x1);
    return (y >= y0) && (y <= y1) && (x >= x0) && (x <= x1);
  endfunction

  int unsigned y;
  int unsigned x;
  int unsigned back_end;
  int unsigned front_end;

  always_comb begin
    y         = 32'(dy_i);
    x         = 32'(dx_i);
    // Legs swap long/short between the two run frames
    back_end  = anim_i ? 75 : 87;
    front_end = anim_i ? 87 : 75;
    bit_o     = 1'b0;
    if (duck_i) begin
      bit_o = (in_span(y, x, 0, 19, 70, 109) && !in_span(y, x, 4, 7, 96, 99)) ||
              in_span(y, x, 10, 39, 0, 79) ||
              in_span(y, x, 40, 51, 20, 29) ||
              in_span(y, x, 40, 51, 50, 59);
    end else begin
      bit_o = (in_span(y, x, 0, 23, 42, 81) && !in_span(y, x, 6, 9, 66, 69)) ||
              in_span(y, x, 24, 63, 10, 61) ||
              in_span(y, x, 30, 45, 0, 9) ||
              in_span(y, x, 64, back_end, 34, 45) ||
              in_span(y, x, 64, front_end, 56, 65);
    end
  end

endmodule

// File: rtl/dino_jump_engine.sv
// Dinosaur motion integrator and sprite renderer.
// Height is integrated once per video frame (falling edge of fresh) from a
// velocity that gravity decrements each frame; ducking in the air doubles
// gravity. On the ground a frame counter toggles the run-leg animation.
// The sprite pixel for the current VGA row/column is registered (1 cycle).
// Ports:
//   clkdiv  pixel clock, all logic on posedge
//   RESET   asynchronous active-high reset
//   bus     slave side of dino_jump_engine_if (controls, video address,
//           px / height / airborne outputs)
module dino_jump_engine
  import dino_pkg::*;
#(
  parameter int unsigned HW       = 10,
  parameter int unsigned V0       = 12,
  parameter int unsigned GRAV     = 1,
  parameter int unsigned GROUND_Y = DefGroundY,
  parameter int unsigned X0       = DefX0,
  parameter int unsigned SPR_W    = DefSprW,
  parameter int unsigned SPR_H    = DefSprH,
  parameter int unsigned DUCK_W   = DefDuckW,
  parameter int unsigned DUCK_H   = DefDuckH,
  parameter int unsigned ANIM_DIV = 6
) (
  input logic               clkdiv,
  input logic               RESET,
  dino_jump_engine_if.slave bus
);

  localparam int unsigned CW  = HW + 2;
  localparam int unsigned ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic                 fresh_q, fresh_d;
  logic                 tick;
  logic [0:0]           state_q, state_d;
  logic [HW-1:0]        h_q, h_d;
  logic signed [CW-1:0] v_q, v_d;
  logic signed [CW-1:0] h_sum;
  logic signed [CW-1:0] g;
  logic                 land;
  logic                 anim_q, anim_d;
  logic [ACW-1:0]       anim_cnt_q, anim_cnt_d;
  logic                 px_q, px_d;

  // Frame tick on the falling edge of fresh
  assign fresh_d = bus.fresh;
  assign tick    = fresh_q & ~bus.fresh;

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    v_d        = v_q;
    anim_d     = anim_q;
    anim_cnt_d = anim_cnt_q;
    g          = bus.button_duck ? CW'(2 * GRAV) : CW'(GRAV);
    // Extra two bits keep the sum signed and overflow-free
    h_sum      = $signed({2'b00, h_q}) + v_q;
    land       = h_sum[CW-1] | (h_sum == '0);
    if (bus.game_status) begin
      if (tick) begin
        unique case (state_q)
          StGround: begin
            if (bus.button_jump) begin
              state_d = StAir;
              h_d     = HW'(V0);
              v_d     = CW'(V0 - GRAV);
            end else if (anim_cnt_q == ACW'(ANIM_DIV - 1)) begin
              anim_cnt_d = '0;
              anim_d     = ~anim_q;
            end else begin
              anim_cnt_d = anim_cnt_q + ACW'(1);
            end
          end
          StAir: begin
            // Landing tick only lands; a held jump relaunches next tick
            if (land) begin
              state_d = StGround;
              h_d     = '0;
              v_d     = '0;
            end else begin
              h_d = h_sum[HW-1:0];
              v_d = v_q - g;
            end
          end
          default: state_d = StGround;
        endcase
      end
    end else if (bus.START) begin
      state_d = StGround;
      h_d     = '0;
      v_d     = '0;
    end
  end

  // Sprite hit test: compare row+h(+H) against GROUND_Y so nothing underflows
  logic          duck;
  logic [CW-1:0] row_w, col_w, spr_h, spr_w, lo_sum, top_sum, gy, x0, dy, dx;
  logic          hit;
  logic          rom_bit;

  always_comb begin
    duck    = bus.button_duck & (state_q == StGround);
    spr_h   = duck ? CW'(DUCK_H) : CW'(SPR_H);
    spr_w   = duck ? CW'(DUCK_W) : CW'(SPR_W);
    gy      = CW'(GROUND_Y);
    x0      = CW'(X0);
    row_w   = CW'(bus.row_addr);
    col_w   = CW'(bus.col_addr);
    lo_sum  = row_w + CW'(h_q);
    top_sum = lo_sum + spr_h;
    hit     = (top_sum >= gy) && (lo_sum < gy) && (col_w >= x0) && (col_w < x0 + spr_w);
    dy      = top_sum - gy;
    dx      = col_w - x0;
    px_d    = hit & rom_bit;
  end

  dino_sprite_rom #(
    .CW (CW)
  ) u_rom (
    .duck_i (duck),
    .anim_i (anim_q),
    .dy_i   (dy),
    .dx_i   (dx),
    .bit_o  (rom_bit)
  );

  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      fresh_q    <= 1'b0;
      state_q    <= StGround;
      h_q        <= '0;
      v_q        <= '0;
      anim_q     <= 1'b0;
      anim_cnt_q <= '0;
      px_q       <= 1'b0;
    end else begin
      fresh_q    <= fresh_d;
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      anim_q     <= anim_d;
      anim_cnt_q <= anim_cnt_d;
      px_q       <= px_d;
    end
  end

  assign bus.px       = px_q;
  assign bus.height   = h_q;
  assign bus.airborne = (state_q == StAir);

endmodule
